// File: rtl/pe_array_pkg.sv
// Shared constants and types for the PE array control path.
// Covers array geometry, the compute window length and the sequencer state set.
package pe_array_pkg;

  localparam int ROW_NUM        = 32;
  localparam int COL_NUM        = 32;
  localparam int COMPUTE_CYCLES = 4;
  localparam int TILE_W         = 16;
  localparam int ROW_W          = 6;
  localparam int CNT_W          = $clog2(COMPUTE_CYCLES);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_NUM);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    W_LATCH,
    FETCH_IF,
    COMPUTE,
    OUT,
    DONE
  } ctrl_state_e;

  // A command is runnable only with 1..ROW_NUM rows and at least one tile.
  function automatic logic cfg_valid(input logic [ROW_W-1:0]  rows,
                                     input logic [TILE_W-1:0] tiles);
    return (rows != '0) && (rows <= ROW_MAX) && (tiles != '0);
  endfunction

endpackage

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the PE array: weight load, per-vector compute window and
// row-sum handoff to the reducer. All outputs are decoded from registered state.
module pe_array_ctrl
  import pe_array_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  cfg_row_num,
  input  logic [TILE_W-1:0] cfg_tile_num,
  input  logic              cfg_pass_if,
  output logic              w_req,
  input  logic              w_ready,
  output logic              if_req,
  input  logic              if_valid,
  output logic [ROW_W-1:0]  array_weight_en,
  output logic              prod_out_en,
  output logic              pe_pass_if,
  output logic              opsum_valid,
  input  logic              opsum_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ctrl_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_num_q;
  logic [TILE_W-1:0] tile_num_q;
  logic [TILE_W-1:0] tile_cnt_q;
  logic [CNT_W-1:0]  comp_cnt_q;
  logic              pass_q;
  logic              err_q;

  logic accept;
  logic reject;
  logic inc_tile;
  logic clr_cnt;
  logic tile_last;
  logic comp_last;

  assign tile_last = (tile_cnt_q == tile_num_q - TILE_W'(1));
  assign comp_last = (comp_cnt_q == CNT_W'(COMPUTE_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    inc_tile = 1'b0;
    clr_cnt  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_valid(cfg_row_num, cfg_tile_num)) begin
            accept  = 1'b1;
            state_d = LOAD_W;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      LOAD_W:   if (w_ready)  state_d = W_LATCH;
      W_LATCH:                state_d = FETCH_IF;
      FETCH_IF: if (if_valid) state_d = COMPUTE;
      COMPUTE:  if (comp_last) state_d = OUT;
      OUT: begin
        if (opsum_ready) begin
          if (tile_last) begin
            state_d  = DONE;
          end else begin
            inc_tile = 1'b1;
            state_d  = FETCH_IF;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Abort wins over any handshake finishing in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      inc_tile = 1'b0;
      clr_cnt  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_num_q  <= '0;
      tile_num_q <= '0;
      pass_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        row_num_q  <= cfg_row_num;
        tile_num_q <= cfg_tile_num;
        pass_q     <= cfg_pass_if;
      end
    end
  end

  // The compute counter restarts while waiting for the next ifmap vector and
  // parks at its last value rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_cnt_q <= '0;
      comp_cnt_q <= '0;
    end else if (accept || clr_cnt) begin
      tile_cnt_q <= '0;
      comp_cnt_q <= '0;
    end else begin
      if (inc_tile) tile_cnt_q <= tile_cnt_q + TILE_W'(1);
      if (state_q == FETCH_IF) begin
        comp_cnt_q <= '0;
      end else if ((state_q == COMPUTE) && !comp_last) begin
        comp_cnt_q <= comp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign w_req           = (state_q == LOAD_W);
  assign if_req          = (state_q == FETCH_IF);
  assign array_weight_en = (state_q == W_LATCH) ? row_num_q : '0;
  assign prod_out_en     = (state_q == COMPUTE);
  assign opsum_valid     = (state_q == OUT);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign pe_pass_if      = pass_q;
  assign err             = err_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl: each command is expanded into a planned
// per-cycle output timeline from segment lengths, then replayed against the DUT.
module tb_pe_array_ctrl;
  import pe_array_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [5:0]  cfg_row_num;
  logic [15:0] cfg_tile_num;
  logic        cfg_pass_if;
  logic        w_req, w_ready, if_req, if_valid;
  logic [5:0]  array_weight_en;
  logic        prod_out_en, pe_pass_if, opsum_valid, opsum_ready;
  logic        busy, done, err;

  pe_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_row_num(cfg_row_num), .cfg_tile_num(cfg_tile_num), .cfg_pass_if(cfg_pass_if),
    .w_req(w_req), .w_ready(w_ready), .if_req(if_req), .if_valid(if_valid),
    .array_weight_en(array_weight_en), .prod_out_en(prod_out_en), .pe_pass_if(pe_pass_if),
    .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Output vector layout: {w_req, if_req, weight_en[5:0], prod, opsum_valid, busy, done, err, pass}
  function automatic logic [13:0] vec(input logic wr, input logic ir, input logic [5:0] wen,
                                      input logic pr, input logic ov, input logic bz,
                                      input logic dn, input logic er, input logic ps);
    return {wr, ir, wen, pr, ov, bz, dn, er, ps};
  endfunction

  function automatic logic [31:0] obs();
    return 32'({w_req, if_req, array_weight_en, prod_out_en, opsum_valid, busy, done, err, pe_pass_if});
  endfunction

  logic        pass_model = 1'b0;
  logic [13:0] exp_q[$];
  logic [2:0]  rsp_q[$];   // {w_ready, if_valid, opsum_ready} to present when requested
  int          first_comp, first_out;
  int          di[8];
  int          dv[8];

  function automatic logic [31:0] idle_vec();
    return 32'(vec(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass_model));
  endfunction

  // Expand one command into its cycle timeline: each phase is a segment whose
  // length is the response delay plus one, compute is a fixed window.
  task automatic build(input int rows, input int tiles, input logic pass, input int dw);
    exp_q.delete();
    rsp_q.delete();
    first_comp = -1;
    first_out  = -1;
    for (int c = 0; c <= dw; c++) begin
      exp_q.push_back(vec(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pass));
      rsp_q.push_back({c == dw, 1'b0, 1'b0});
    end
    exp_q.push_back(vec(1'b0, 1'b0, 6'(rows), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pass));
    rsp_q.push_back(3'b000);
    for (int t = 0; t < tiles; t++) begin
      for (int c = 0; c <= di[t]; c++) begin
        exp_q.push_back(vec(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pass));
        rsp_q.push_back({1'b0, c == di[t], 1'b0});
      end
      for (int c = 0; c < COMPUTE_CYCLES; c++) begin
        if (t == 0 && c == 0) first_comp = exp_q.size();
        exp_q.push_back(vec(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pass));
        rsp_q.push_back(3'b000);
      end
      for (int c = 0; c <= dv[t]; c++) begin
        if (t == 0 && c == 0) first_out = exp_q.size();
        exp_q.push_back(vec(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pass));
        rsp_q.push_back({1'b0, 1'b0, c == dv[t]});
      end
    end
    exp_q.push_back(vec(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pass));
    rsp_q.push_back(3'b000);
  endtask

  task automatic rand_cfg();
    cfg_row_num  = 6'($urandom_range(0, 63));
    cfg_tile_num = 16'($urandom_range(0, 7));
    cfg_pass_if  = 1'($urandom);
  endtask

  // kmode: 0 none, 1 abort at random cycle, 2 abort at compute cycle 2 of tile 0,
  // 3 async reset in the first OUT cycle.
  task automatic run_cmd(input int rows, input int tiles, input logic pass, input int dw,
                         input int kmode, output int done_cyc);
    int n;
    int kidx;
    build(rows, tiles, pass, dw);
    n    = exp_q.size();
    kidx = -1;
    if (kmode == 1) kidx = $urandom_range(0, n - 1);
    if (kmode == 2) kidx = first_comp + 2;
    if (kmode == 3) kidx = first_out;
    done_cyc     = -1;
    start        = 1'b1;
    abort        = 1'b0;
    cfg_row_num  = 6'(rows);
    cfg_tile_num = 16'(tiles);
    cfg_pass_if  = pass;
    @(posedge clk); #1;
    pass_model = pass;
    for (int i = 0; i < n; i++) begin
      check($sformatf("cmd_cyc%0d", i + 1), obs(), 32'(exp_q[i]));
      if (done) done_cyc = i + 1;
      if (kmode == 3 && i == kidx) begin
        #1 reset = 1'b0;
        #1 check("rst_async", obs(), 32'd0);
        pass_model = 1'b0;
        @(posedge clk); #1;
        check("rst_hold", obs(), 32'd0);
        reset = 1'b1;
        break;
      end
      w_ready     = exp_q[i][13] ? rsp_q[i][2] : 1'($urandom);
      if_valid    = exp_q[i][12] ? rsp_q[i][1] : 1'($urandom);
      opsum_ready = exp_q[i][4]  ? rsp_q[i][0] : 1'($urandom);
      start       = ($urandom_range(0, 2) == 0);
      rand_cfg();
      abort       = (kmode inside {1, 2}) && (i == kidx);
      @(posedge clk); #1;
      if (abort) break;
    end
    start = 1'b0;
    abort = 1'b0;
    check("cmd_idle", obs(), idle_vec());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start       = 1'b0;
      abort       = 1'($urandom);
      w_ready     = 1'($urandom);
      if_valid    = 1'($urandom);
      opsum_ready = 1'($urandom);
      rand_cfg();
      @(posedge clk); #1;
      check("idle", obs(), idle_vec());
    end
    abort = 1'b0;
  endtask

  task automatic reject(input int rows, input int tiles);
    start        = 1'b1;
    cfg_row_num  = 6'(rows);
    cfg_tile_num = 16'(tiles);
    cfg_pass_if  = ~pass_model;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("rej_err_r%0d_t%0d", rows, tiles), obs(),
          32'(vec(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pass_model)));
    @(posedge clk); #1;
    check("rej_clear", obs(), idle_vec());
  endtask

  task automatic zero_delays();
    for (int t = 0; t < 8; t++) begin
      di[t] = 0;
      dv[t] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    int rows, tiles, dw, kmode;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    w_ready = 1'b0; if_valid = 1'b0; opsum_ready = 1'b0;
    cfg_row_num = '0; cfg_tile_num = '0; cfg_pass_if = 1'b0;
    #12;
    check("reset_outputs", obs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);

    zero_delays();
    run_cmd(32, 3, 1'b1, 0, 0, dc);
    check("basic_done_cycle", 32'(dc), 32'd21);

    run_cmd(5, 2, 1'b0, 0, 0, dc);
    check("partial_done_cycle", 32'(dc), 32'd15);

    dv[1] = 7;
    run_cmd(17, 3, 1'b1, 0, 0, dc);
    check("bp_done_cycle", 32'(dc), 32'd28);
    zero_delays();

    reject(16, 0);
    reject(40, 2);
    reject(0, 1);
    reject(33, 1);

    run_cmd(32, 3, 1'b0, 1, 2, dc);
    check("abort_no_done", 32'(dc), 32'hffff_ffff);
    idle_cycles(2);
    run_cmd(8, 2, 1'b1, 0, 0, dc);
    check("post_abort_done_cycle", 32'(dc), 32'd15);

    run_cmd(12, 2, 1'b1, 0, 3, dc);
    check("reset_no_done", 32'(dc), 32'hffff_ffff);
    idle_cycles(3);
    run_cmd(20, 1, 1'b0, 0, 0, dc);
    check("post_reset_done_cycle", 32'(dc), 32'd9);

    for (int k = 0; k < 30; k++) begin
      rows  = $urandom_range(1, 32);
      tiles = $urandom_range(1, 5);
      dw    = $urandom_range(0, 3);
      for (int t = 0; t < 8; t++) begin
        di[t] = $urandom_range(0, 3);
        dv[t] = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 2);
      end
      kmode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run_cmd(rows, tiles, 1'($urandom), dw, kmode, dc);
      if ($urandom_range(0, 3) == 0) reject($urandom_range(33, 63), $urandom_range(1, 5));
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
